// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing, control-state type and bit-reverse helper
package fft_pkg;

  localparam int FFT_N          = 16;
  localparam int FFT_ADDR_W     = 4;
  localparam int FFT_DATA_W     = 16;
  localparam int FFT_MAX_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fft_state_t;

  // Reverses the low 'width' bits of value; bits at and above 'width' come back zero.
  function automatic logic [FFT_MAX_ADDR_W-1:0] bit_reverse(
    input logic [FFT_MAX_ADDR_W-1:0] value,
    input int                        width
  );
    logic [FFT_MAX_ADDR_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < FFT_MAX_ADDR_W; i++) begin
      if (i < width) begin
        rev[i] = value[width-1-i];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_output_reader_if.sv
// rtl/fft_output_reader_if.sv - natural-order bin stream leaving the FFT output reader
interface fft_output_reader_if
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W
);

  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_data;
  logic [ADDR_W-1:0]     out_index;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/fft_skid_fifo.sv
// rtl/fft_skid_fifo.sv - two-entry synchronous FIFO with registered head and occupancy
module fft_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign pop_ok  = pop && (occupancy != 2'd0);
  assign push_ok = push && ((occupancy != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot[0]   <= '0;
      slot[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push_ok) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      occupancy <= occupancy + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign head_data  = slot[rd_ptr];
  assign head_valid = (occupancy != 2'd0);

endmodule

// File: rtl/fft_output_reader.sv
// rtl/fft_output_reader.sv - unloads a bit-reversed FFT result memory as a natural-order stream
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [2*DATA_W-1:0] mem_rd_data,
  fft_output_reader_if.master out,
  output logic                done
);

  localparam int                ENTRY_W  = 2*DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N-1);

  fft_state_t          state;
  logic [ADDR_W-1:0]   rd_cnt;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pend_idx;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                head_valid;
  logic                head_last;
  logic [1:0]          occupancy;
  logic                pop;
  logic [2:0]          committed;
  logic                issue;

  assign busy = (state != ST_IDLE);
  assign pop  = head_valid && out.out_ready;

  // Entries already owed to the FIFO; a new read lands one cycle after issue,
  // so allowing committed < 2 keeps the FIFO within two entries at full rate.
  assign committed = 3'(occupancy) + 3'(pend_valid) - 3'(pop);
  assign issue     = reset && (state == ST_READ) && (committed < 3'd2);

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? ADDR_W'(bit_reverse(FFT_MAX_ADDR_W'(rd_cnt), ADDR_W)) : '0;

  assign push_entry = {(pend_idx == LAST_IDX), pend_idx, mem_rd_data};

  fft_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (pend_valid),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  assign {head_last, out.out_index, out.out_data} = head_entry;
  assign out.out_last  = head_last;
  assign out.out_valid = head_valid;

  // Clearing pend_valid on reset drops any read still returning from memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_cnt     <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      done       <= 1'b0;
    end else begin
      pend_valid <= issue;
      pend_idx   <= rd_cnt;
      done       <= pop && head_last;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_READ;
            rd_cnt <= '0;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (rd_cnt == LAST_IDX) begin
              state <= ST_DRAIN;
            end else begin
              rd_cnt <= rd_cnt + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_output_reader.sv
// tb/tb_fft_output_reader.sv - directed and random-backpressure bench for fft_output_reader
module tb_fft_output_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic        done;

  logic        dir_ready;
  logic        rand_ready;
  logic        rand_mode;

  logic [31:0] mem [16];
  beat_t       exp_q [$];

  int vectors;
  int miscompares;
  int done_cnt;
  int exp_done;
  int rd_k;

  logic        stall_prev;
  logic        last_prev;
  logic [31:0] hold_data;
  logic [3:0]  hold_idx;
  logic        hold_last;

  fft_output_reader_if #(.ADDR_W(4), .DATA_W(16)) ifc ();

  fft_output_reader #(.N(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out         (ifc),
    .done        (done)
  );

  assign ifc.out_ready = rand_mode ? rand_ready : dir_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  always @(posedge clk) begin
    #1;
    rand_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int f);
    for (int a = 0; a < 16; a++) mem[a] = (f == 0) ? 32'(a) : $urandom;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 16; i++) begin
      beat_t b;
      b.data = mem[rev4(4'(i))];
      b.idx  = 4'(i);
      b.last = (i == 15);
      exp_q.push_back(b);
    end
    exp_done++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic start_frame(input int f);
    fill_mem(f);
    push_frame();
    pulse_start();
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      rd_k       = 0;
      stall_prev = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (mem_rd_en) begin
        chk("rd_addr", 64'(mem_addr), 64'(rev4(4'(rd_k))));
        rd_k = (rd_k + 1) % 16;
      end else begin
        chk("addr_zero_idle", 64'(mem_addr), 64'd0);
      end
      chk("fifo_occ_le2", 64'(dut.u_fifo.occupancy <= 2'd2), 64'd1);
      chk("done_after_last", 64'(done), 64'(last_prev));
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("hold_valid", 64'(ifc.out_valid), 64'd1);
        chk("hold_data", 64'(ifc.out_data), 64'(hold_data));
        chk("hold_index", 64'(ifc.out_index), 64'(hold_idx));
        chk("hold_last", 64'(ifc.out_last), 64'(hold_last));
      end
      last_prev = 1'b0;
      if (ifc.out_valid && ifc.out_ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", 64'(ifc.out_data), 64'(b.data));
          chk("beat_index", 64'(ifc.out_index), 64'(b.idx));
          chk("beat_last", 64'(ifc.out_last), 64'(b.last));
        end
        last_prev = ifc.out_last;
      end
      stall_prev = ifc.out_valid && !ifc.out_ready;
      hold_data  = ifc.out_data;
      hold_idx   = ifc.out_index;
      hold_last  = ifc.out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    exp_done    = 0;
    rd_k        = 0;
    reset       = 1'b0;
    start       = 1'b0;
    dir_ready   = 1'b1;
    rand_mode   = 1'b0;
    mem_rd_data = '0;
    fill_mem(0);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_data", 64'(ifc.out_data), 64'd0);
    chk("rst_index", 64'(ifc.out_index), 64'd0);
    chk("rst_last", 64'(ifc.out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Full-rate frame with cycle-exact timing against the start edge
    start_frame(0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk("t1_rd_en", 64'(mem_rd_en), 64'(k <= 16));
      chk("t1_valid", 64'(ifc.out_valid), 64'(k >= 3 && k <= 18));
      chk("t1_busy", 64'(busy), 64'(k <= 18));
      chk("t1_done", 64'(done), 64'(k == 19));
      tick();
    end
    repeat (3) tick();

    // Backpressure during cycles T+5..T+9
    start_frame(1);
    repeat (4) tick();
    dir_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_rd_stop_a", 64'(mem_rd_en), 64'd0);
    tick();
    @(negedge clk);
    chk("t3_rd_stop_b", 64'(mem_rd_en), 64'd0);
    repeat (3) tick();
    dir_ready = 1'b1;
    wait_done(80);
    repeat (3) tick();
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start re-pulsed mid-frame is ignored
    start_frame(2);
    repeat (5) tick();
    pulse_start();
    wait_done(80);
    repeat (10) tick();
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_single_done", 64'(done_cnt), 64'(exp_done));

    // Reset pulse at T+8 aborts the frame
    start_frame(3);
    exp_done--;
    repeat (7) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t5_addr", 64'(mem_addr), 64'd0);
    chk("t5_valid", 64'(ifc.out_valid), 64'd0);
    chk("t5_data", 64'(ifc.out_data), 64'd0);
    chk("t5_index", 64'(ifc.out_index), 64'd0);
    chk("t5_last", 64'(ifc.out_last), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    repeat (10) tick();
    chk("t5_no_done", 64'(done_cnt), 64'(exp_done));
    start_frame(4);
    wait_done(80);
    repeat (2) tick();
    chk("t5_fresh_frame", 64'(exp_q.size()), 64'd0);

    // Back-to-back frames: second start lands in the done cycle
    start_frame(5);
    wait_done(80);
    fill_mem(6);
    push_frame();
    pulse_start();
    wait_done(80);
    repeat (3) tick();
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_done_count", 64'(done_cnt), 64'(exp_done));

    // Random backpressure over 20 frames
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      start_frame(10 + f);
      wait_done(400);
    end
    rand_mode = 1'b0;
    repeat (5) tick();
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("total_done", 64'(done_cnt), 64'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_output_reader.md
FFT_OUTPUT_READER -- requirements
Module: fft_output_reader

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT points per frame.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning result-memory address width (log2 N).
REQ-003 SHALL have parameter DATA_W, default 16, meaning width of each real/imag component.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-low reset (0 = reset, sampled on clk).
REQ-006 SHALL have port start, input, 1, meaning one-cycle pulse: the FFT engine has finished writing a frame to result memory.
REQ-007 SHALL have port busy, output, 1, meaning a frame unload is in progress.
REQ-008 SHALL have port mem_rd_en, output, 1, meaning result-memory read strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W, meaning result-memory read address.
REQ-010 SHALL have port mem_rd_data, input, 2*DATA_W, meaning {re,im} read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 2*DATA_W), meaning valid/ready output stream.
REQ-012 SHALL have port out_index, output, ADDR_W, meaning natural-order bin number of the current beat.
REQ-013 SHALL have port out_last, output, 1, meaning high on bin N-1 beat.
REQ-014 SHALL have port done, output, 1, meaning one-cycle pulse after the last beat transfers.

Function
REQ-015 SHALL implement FSM IDLE -> READ (on start) -> DRAIN (all N reads issued) -> IDLE (last beat accepted).
REQ-016 SHALL issue reads for k = 0..N-1 in order with mem_addr = bit-reverse(k) over ADDR_W bits, so bins leave in natural order.
REQ-017 SHALL drive mem_addr = 0 whenever mem_rd_en = 0.
REQ-018 SHALL assert first mem_rd_en in cycle T+1 when start is sampled at edge T; first out_valid in cycle T+3.
REQ-019 SHALL buffer read data in a 2-entry FIFO and issue a read only when (FIFO occupancy + reads in flight - pop this cycle) < 2; FIFO SHALL never overflow.
REQ-020 SHALL sustain one beat per cycle while out_ready is held high (N beats in N consecutive cycles).
REQ-021 SHALL transfer a beat only when out_valid && out_ready; out_data/out_index/out_last SHALL be held stable while out_valid && !out_ready.
REQ-022 SHALL ignore start while busy = 1 (no restart, no error).
REQ-023 SHALL hold busy = 1 from cycle T+1 through the cycle of the last beat transfer.
REQ-024 SHALL pulse done for exactly one cycle, the cycle after the last beat transfer; start in that cycle SHALL be accepted.
REQ-025 SHALL wrap the read counter from N-1 to 0 only on frame completion, never mid-frame.

Reset
REQ-026 SHALL, while reset = 0, force state IDLE, counters 0, FIFO empty, busy 0, mem_rd_en 0, mem_addr 0, out_valid 0, out_data 0, out_index 0, out_last 0, done 0.
REQ-027 SHALL abort a frame on reset mid-operation: in-flight read data returning after reset release is discarded; no done pulse.

Structure
REQ-028 SHALL take N, ADDR_W, DATA_W defaults, the FSM state typedef and the bit-reverse function from shared package fft_pkg, also used by the FFT control block.
REQ-029 SHALL instantiate one sub-module fft_skid_fifo (2-entry, synchronous, occupancy output) for output buffering.

Verification
REQ-030 SHALL cover: memory preloaded word[a] = a, start at T, out_ready = 1 -> reads addr 0,8,4,12,2,... cycles T+1..T+16; beats T+3..T+18 with out_data = bitrev(index) per index 0..15, out_last at index 15, done at T+19.
REQ-031 SHALL cover: out_ready low cycles T+5..T+9 -> outputs stable, mem_rd_en stops within 2 cycles, no lost or duplicated bins, order 0..15 preserved.
REQ-032 SHALL cover: start re-pulsed at T+6 -> ignored, exactly 16 beats, single done.
REQ-033 SHALL cover: reset = 0 at T+8 for 1 cycle -> all outputs at reset values next cycle, no done, fresh start afterwards produces a full correct frame.
REQ-034 SHALL cover: start in the done cycle -> second frame begins, back-to-back frames with 32 correct beats and two done pulses.
REQ-035 SHALL cover: random out_ready (50%) over 20 frames -> scoreboard match, FIFO occupancy never > 2.
